// File: rtl/cskipa_pipe_if.sv
// Operand/result handshake bundle for cskipa_pipe.
// The ovf member exists only when CSKIPA_OVF_EN is defined.
interface cskipa_pipe_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add_term1;
  logic [WIDTH-1:0] i_add_term2;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CSKIPA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output i_valid, i_add_term1, i_add_term2, i_ready,
    input  o_ready, o_valid, sum, cout
`ifdef CSKIPA_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  i_valid, i_add_term1, i_add_term2, i_ready,
    output o_ready, o_valid, sum, cout
`ifdef CSKIPA_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/cskipa_pipe.sv
// Pipelined carry-skip adder: STAGES cycles latency, one beat per cycle; a low i_ready holds the output and
// fills upstream stages until o_ready drops. Define CSKIPA_OVF_EN to add the registered signed-overflow flag.
module cskipa_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  cskipa_pipe_if.slave bus
);
  localparam int NB  = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int BPS = (NB + STAGES - 1) / STAGES;

  // Index s holds what stage s consumes: raw operands, partial sum, carry, valid.
  logic [WIDTH-1:0]  in_a [STAGES];
  logic [WIDTH-1:0]  in_b [STAGES];
  logic [WIDTH-1:0]  in_s [STAGES];
  logic [STAGES-1:0] in_c;
  logic [STAGES-1:0] in_v;
  logic [STAGES-1:0] ld;

  logic             out_vld;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             fire;

  assign in_a[0] = bus.i_add_term1;
  assign in_b[0] = bus.i_add_term2;
  assign in_s[0] = '0;
  assign in_c[0] = 1'b0;
  assign in_v[0] = bus.i_valid;

  assign fire        = out_vld & bus.i_ready;
  assign bus.o_ready = ld[0];
  assign bus.o_valid = out_vld;
  assign bus.sum     = out_sum;
  assign bus.cout    = out_cout;
`ifdef CSKIPA_OVF_EN
  logic out_ovf;
  assign bus.ovf = out_ovf;
`endif

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LB  = s * BPS;
    localparam int HB  = ((s + 1) * BPS < NB) ? (s + 1) * BPS : NB;
    localparam int NBS = (HB > LB) ? HB - LB : 0;

    logic [WIDTH-1:0] st_sum;
    logic [NBS:0]     bc;

    assign bc[0] = in_c[s];

    for (genvar k = 0; k < NB; k++) begin : g_blk
      localparam int LO = k * BLOCK;
      localparam int HI = (((k + 1) * BLOCK < WIDTH) ? (k + 1) * BLOCK : WIDTH) - 1;
      localparam int BW = HI - LO + 1;

      if (k >= LB && k < HB) begin : g_add
        logic [BW-1:0] pa;
        logic [BW-1:0] ga;
        logic [BW:0]   rc;

        assign pa    = in_a[s][HI:LO] ^ in_b[s][HI:LO];
        assign ga    = in_a[s][HI:LO] & in_b[s][HI:LO];
        assign rc[0] = bc[k-LB];
        for (genvar j = 0; j < BW; j++) begin : g_bit
          assign rc[j+1] = ga[j] | (pa[j] & rc[j]);
        end
        assign st_sum[HI:LO] = pa ^ rc[BW-1:0];
        // A fully propagating block forwards its carry-in without waiting on the ripple.
        assign bc[k-LB+1]    = (&pa) ? bc[k-LB] : rc[BW];
      end else begin : g_pass
        assign st_sum[HI:LO] = in_s[s][HI:LO];
      end
    end

    if (s < STAGES - 1) begin : g_mid
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;

      assign ld[s] = !v_q || ld[s+1];

      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (ld[s]) begin
          v_q <= in_v[s];
          a_q <= in_a[s];
          b_q <= in_b[s];
          s_q <= st_sum;
          c_q <= bc[NBS];
        end
      end

      assign in_a[s+1] = a_q;
      assign in_b[s+1] = b_q;
      assign in_s[s+1] = s_q;
      assign in_c[s+1] = c_q;
      assign in_v[s+1] = v_q;
    end else begin : g_last
      assign ld[s] = !out_vld || fire;

      always_ff @(posedge clk) begin
        if (rst) begin
          out_vld  <= 1'b0;
          out_sum  <= '0;
          out_cout <= 1'b0;
`ifdef CSKIPA_OVF_EN
          out_ovf  <= 1'b0;
`endif
        end else if (ld[s]) begin
          out_vld <= in_v[s];
          if (in_v[s]) begin
            out_sum  <= st_sum;
            out_cout <= bc[NBS];
`ifdef CSKIPA_OVF_EN
            out_ovf  <= (in_a[s][WIDTH-1] == in_b[s][WIDTH-1]) &&
                        (st_sum[WIDTH-1] != in_a[s][WIDTH-1]);
`endif
          end
        end
      end
    end
  end
endmodule
